// File: rtl/ruler_pkg.sv
// Shared constants for the ruler_scan scanning-light generator.
package ruler_pkg;

  // End-of-travel behaviour selected by mode_i
  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_STOP   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Direction encoding: right moves toward bit 0
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/ruler_tick.sv
// ruler_tick: free-running prescaler producing a one-cycle tick every PRESCALE
// cycles while run_i is high. Dropping run_i clears the count.
module ruler_tick #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  output logic tick_o
);

  // A PRESCALE of 1 still needs a one-bit counter to stay legal
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CntMax = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick fires on the last count of each period
  always_comb begin
    tick_o = run_i && (cnt_q == CntMax);
  end

  // Next count: clear when stopped or at end of period
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!run_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ruler_scan.sv
// ruler_scan: moving one-hot (or bar-graph) light with wrap/bounce/stop/hold
// end behaviour. Steps come from stb_i or the internal ruler_tick prescaler.
// Optional feature macro: RULER_SCAN_BAR_EN enables the bar-graph decode on bar_i.
module ruler_scan
  import ruler_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     run_i,
  input  logic                     stb_i,
  input  logic                     dir_i,
  input  logic [1:0]               mode_i,
  input  logic                     bar_i,
  output logic [WIDTH-1:0]         ruler_o,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic                     dir_o,
  output logic                     edge_o
);

  localparam int unsigned PW = $clog2(WIDTH);
  localparam logic [PW-1:0] PosMax = PW'(WIDTH - 1);

  logic          tick;
  logic          step;
  logic          at_end;
  logic [PW-1:0] pos_move;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          edge_q, edge_d;

  ruler_tick #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .run_i   (run_i),
    .tick_o  (tick)
  );

  // Strobe and tick merge into a single step
  always_comb begin
    step     = stb_i | tick;
    // at_end is direction-aware: R at WIDTH-1 is an ordinary move
    at_end   = (dir_q == DIR_RIGHT) ? (pos_q == '0) : (pos_q == PosMax);
    pos_move = (dir_q == DIR_RIGHT) ? (pos_q - PW'(1)) : (pos_q + PW'(1));
  end

  // Next position, direction and edge flag
  always_comb begin
    pos_d = pos_q;
    dir_d = (mode_i == MODE_BOUNCE) ? dir_q : dir_i;
    if (step) begin
      unique case (mode_i)
        MODE_WRAP: begin
          if (at_end) begin
            pos_d = (dir_q == DIR_RIGHT) ? PosMax : '0;
          end else begin
            pos_d = pos_move;
          end
        end
        MODE_BOUNCE: begin
          if (at_end) begin
            if (dir_q == DIR_RIGHT) begin
              dir_d = DIR_LEFT;
              pos_d = PW'(1);
            end else begin
              dir_d = DIR_RIGHT;
              pos_d = PosMax - PW'(1);
            end
          end else begin
            pos_d = pos_move;
          end
        end
        MODE_STOP: begin
          if (!at_end) begin
            pos_d = pos_move;
          end
        end
        MODE_HOLD: begin
          pos_d = pos_q;
        end
      endcase
    end
    edge_d = step && ((pos_d == '0) || (pos_d == PosMax));
  end

  // State registers; reset wins over any coincident step
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pos_q  <= '0;
      dir_q  <= DIR_RIGHT;
      edge_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      edge_q <= edge_d;
    end
  end

`ifdef RULER_SCAN_BAR_EN
  // Display decode: thermometer pos..0 when bar_i, else one-hot
  always_comb begin
    ruler_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ruler_o[i] = bar_i ? (PW'(i) <= pos_q) : (PW'(i) == pos_q);
    end
  end
`else
  // bar_i has no function in this build
  logic unused_bar;
  assign unused_bar = bar_i;

  // Display decode: one-hot at pos
  always_comb begin
    ruler_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ruler_o[i] = (PW'(i) == pos_q);
    end
  end
`endif

  // Output aliases
  always_comb begin
    pos_o  = pos_q;
    dir_o  = dir_q;
    edge_o = edge_q;
  end

endmodule

// File: tb/tb_ruler_scan.sv
// Directed bench for ruler_scan: an 8-wide instance for wrap/stop/reset/bar/
// prescaler sequences and a 5-wide instance for bounce.
module tb_ruler_scan;
  import ruler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       run8, stb8, dir8, bar8;
  logic [1:0] mode8;
  logic [7:0] ruler8;
  logic [2:0] pos8;
  logic       dirq8, edge8;

  logic       run5, stb5, dir5, bar5;
  logic [1:0] mode5;
  logic [4:0] ruler5;
  logic [2:0] pos5;
  logic       dirq5, edge5;

  ruler_scan #(.WIDTH(8), .PRESCALE(4)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run8), .stb_i(stb8), .dir_i(dir8),
    .mode_i(mode8), .bar_i(bar8), .ruler_o(ruler8), .pos_o(pos8), .dir_o(dirq8),
    .edge_o(edge8)
  );

  ruler_scan #(.WIDTH(5), .PRESCALE(4)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run5), .stb_i(stb5), .dir_i(dir5),
    .mode_i(mode5), .bar_i(bar5), .ruler_o(ruler5), .pos_o(pos5), .dir_o(dirq5),
    .edge_o(edge5)
  );

  typedef struct {
    logic       tgt;   // 0 = dut8, 1 = dut5
    logic       rst;
    logic       stb;
    logic       dir;
    logic [1:0] mode;
    logic [2:0] pos;
    logic       dirx;
    logic       edg;
    logic [7:0] ruler;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic tgt, input logic rst, input logic stb, input logic dir,
                     input logic [1:0] mode, input logic [2:0] pos, input logic dirx,
                     input logic edg, input logic [7:0] ruler);
    vec_t v;
    v = '{tgt, rst, stb, dir, mode, pos, dirx, edg, ruler};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run8 = 1'b0; stb8 = 1'b0; dir8 = 1'b1; bar8 = 1'b0; mode8 = MODE_WRAP;
    run5 = 1'b0; stb5 = 1'b0; dir5 = 1'b0; bar5 = 1'b0; mode5 = MODE_BOUNCE;

    // Reset, then wrap right from 0
    add(0, 1, 0, 1, MODE_WRAP, 0, 1, 0, 8'h01);
    add(0, 0, 1, 1, MODE_WRAP, 7, 1, 1, 8'h80);
    add(0, 0, 0, 1, MODE_WRAP, 7, 1, 0, 8'h80);
    add(0, 0, 1, 1, MODE_WRAP, 6, 1, 0, 8'h40);
    add(0, 0, 1, 1, MODE_WRAP, 5, 1, 0, 8'h20);
    add(0, 0, 1, 1, MODE_WRAP, 4, 1, 0, 8'h10);
    add(0, 0, 1, 1, MODE_WRAP, 3, 1, 0, 8'h08);
    // Reset with a coincident step: reset wins
    add(0, 1, 1, 1, MODE_STOP, 0, 1, 0, 8'h01);
    // STOP moving left, pinned at 7, then reverse
    add(0, 0, 0, 0, MODE_STOP, 0, 0, 0, 8'h01);
    add(0, 0, 1, 0, MODE_STOP, 1, 0, 0, 8'h02);
    add(0, 0, 1, 0, MODE_STOP, 2, 0, 0, 8'h04);
    add(0, 0, 1, 0, MODE_STOP, 3, 0, 0, 8'h08);
    add(0, 0, 1, 0, MODE_STOP, 4, 0, 0, 8'h10);
    add(0, 0, 1, 0, MODE_STOP, 5, 0, 0, 8'h20);
    add(0, 0, 1, 0, MODE_STOP, 6, 0, 0, 8'h40);
    add(0, 0, 1, 0, MODE_STOP, 7, 0, 1, 8'h80);
    add(0, 0, 1, 0, MODE_STOP, 7, 0, 1, 8'h80);
    add(0, 0, 1, 0, MODE_STOP, 7, 0, 1, 8'h80);
    add(0, 0, 0, 1, MODE_STOP, 7, 1, 0, 8'h80);
    add(0, 0, 1, 1, MODE_STOP, 6, 1, 0, 8'h40);
    add(0, 0, 1, 1, MODE_STOP, 5, 1, 0, 8'h20);
    // BOUNCE on the 5-wide instance; dir_i toggles and must be ignored
    add(1, 0, 1, 0, MODE_BOUNCE, 1, 0, 0, 8'h02);
    add(1, 0, 1, 1, MODE_BOUNCE, 2, 0, 0, 8'h04);
    add(1, 0, 1, 0, MODE_BOUNCE, 3, 0, 0, 8'h08);
    add(1, 0, 1, 1, MODE_BOUNCE, 4, 0, 1, 8'h10);
    add(1, 0, 1, 0, MODE_BOUNCE, 3, 1, 0, 8'h08);
    add(1, 0, 1, 1, MODE_BOUNCE, 2, 1, 0, 8'h04);
    add(1, 0, 1, 0, MODE_BOUNCE, 1, 1, 0, 8'h02);
    add(1, 0, 1, 1, MODE_BOUNCE, 0, 1, 1, 8'h01);
    add(1, 0, 1, 0, MODE_BOUNCE, 1, 0, 0, 8'h02);
    add(1, 0, 1, 1, MODE_BOUNCE, 2, 0, 0, 8'h04);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst_n = !vq[i].rst;
      if (vq[i].tgt == 1'b0) begin
        stb8 = vq[i].stb; dir8 = vq[i].dir; mode8 = vq[i].mode; stb5 = 1'b0;
      end else begin
        stb5 = vq[i].stb; dir5 = vq[i].dir; mode5 = vq[i].mode; stb8 = 1'b0;
      end
      @(negedge clk);
      if (vq[i].tgt == 1'b0) begin
        check($sformatf("v%0d pos", i), pos8, vq[i].pos);
        check($sformatf("v%0d dir", i), dirq8, vq[i].dirx);
        check($sformatf("v%0d edge", i), edge8, vq[i].edg);
        check($sformatf("v%0d ruler", i), ruler8, vq[i].ruler);
      end else begin
        check($sformatf("v%0d pos5", i), pos5, vq[i].pos);
        check($sformatf("v%0d dir5", i), dirq5, vq[i].dirx);
        check($sformatf("v%0d edge5", i), edge5, vq[i].edg);
        check($sformatf("v%0d ruler5", i), {3'b000, ruler5}, vq[i].ruler);
      end
    end
    stb5 = 1'b0;

    // Reset mid-sequence at pos 5 with a step requested
    rst_n = 1'b0; stb8 = 1'b1; dir8 = 1'b0;
    @(negedge clk);
    check("midrst pos", pos8, 0);
    check("midrst ruler", ruler8, 8'h01);
    check("midrst dir", dirq8, 1);
    check("midrst edge", edge8, 0);

    // Move left to pos 3
    rst_n = 1'b1; stb8 = 1'b0; dir8 = 1'b0; mode8 = MODE_WRAP;
    @(negedge clk);
    stb8 = 1'b1;
    repeat (3) @(negedge clk);
    stb8 = 1'b0;
    check("walk pos3", pos8, 3);

    // Bar decode is combinational
    bar8 = 1'b1;
    #1;
`ifdef RULER_SCAN_BAR_EN
    check("bar on", ruler8, 8'h0F);
`else
    check("bar ignored", ruler8, 8'h08);
`endif
    bar8 = 1'b0;
    #1;
    check("bar off", ruler8, 8'h08);

    // HOLD ignores steps
    mode8 = MODE_HOLD; stb8 = 1'b1;
    repeat (2) @(negedge clk);
    check("hold pos", pos8, 3);
    stb8 = 1'b0; mode8 = MODE_WRAP;

    // Prescaler: ticks at cycles 4, 8, 12; strobe coincident with cycle 8
    run8 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      stb8 = (k == 8);
      @(negedge clk);
      check($sformatf("tick k%0d pos", k), pos8, 3 + k / 4);
    end
    stb8 = 1'b0; run8 = 1'b0;
    repeat (2) @(negedge clk);
    check("run off pos", pos8, 6);

    // Restart: count was cleared, so first tick is 4 cycles out
    run8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("restart k%0d pos", k), pos8, (k == 4) ? 7 : 6);
    end
    check("restart edge", edge8, 1);
    run8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ruler_scan.md
# ruler_scan

Parametrised scanning-light generator: drives a WIDTH-bit one-hot (or, optionally, bar-graph) pattern that moves one position per step. Steps come from an external strobe or a built-in prescaler. Three end-of-travel modes are supported: wrap, bounce and stop. It sits between the board clock domain and an LED/segment output bank, replacing the fixed 8-bit wrap-only ruler.

## Interface
- WIDTH, 8, number of output positions; legal range is WIDTH ≥ 2.
- PRESCALE, 50_000_000, clock cycles per internal tick; legal range is PRESCALE ≥ 1.
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_n_i  input  1  reset, synchronous and active-low.
- run_i  input  1  enables the internal prescaler; low clears the prescaler count.
- stb_i  input  1  external step request, one cycle wide.
- dir_i  input  1  requested direction; 1 = right (toward bit 0), 0 = left (toward bit WIDTH-1).
- mode_i  input  2  end behaviour: 00 WRAP, 01 BOUNCE, 10 STOP, 11 HOLD.
- bar_i  input  1  bar-graph display select; only effective with RULER_SCAN_BAR_EN.
- ruler_o  output  WIDTH  display pattern.
- pos_o  output  PW  current position index, where PW = $clog2(WIDTH).
- dir_o  output  1  effective direction register.
- edge_o  output  1  one-cycle pulse when the position lands on 0 or WIDTH-1.

## Operation
- step = stb_i OR tick. If both are asserted in the same cycle, exactly one step occurs.
- Prescaler:
  - cnt counts 0..PRESCALE-1 while run_i = 1.
  - tick = 1 in the cycle where run_i = 1 and cnt = PRESCALE-1; cnt then returns to 0.
  - When run_i = 0, cnt is cleared to 0 and tick = 0.
- Direction register dir_q:
  - In WRAP, STOP and HOLD, dir_q <= dir_i every cycle.
  - In BOUNCE, dir_i is ignored and dir_q is only changed by reflection.
- Position update on a step (R = right, L = left):
  - Not at an edge: pos moves one in direction dir_q (R decrements, L increments).
  - WRAP at an edge: R at 0 goes to WIDTH-1; L at WIDTH-1 goes to 0.
  - BOUNCE at an edge: R at 0 sets dir_q to L and pos to 1; L at WIDTH-1 sets dir_q to R and pos to WIDTH-2. The end position is therefore shown once per pass.
  - STOP at an edge: pos holds; dir_q still follows dir_i, so reversing dir_i resumes motion.
  - HOLD: pos and dir_q do not change on steps. cnt keeps running.
- Mode changes take effect on the next step. pos is never reset by a mode change.
- edge_o is registered. It equals 1 in the cycle after a step whose new pos is 0 or WIDTH-1, including STOP steps that hold at the edge.
- ruler_o is a combinational decode of pos_q:
  - One-hot: bit pos_q set.
  - Bar: bits pos_q..0 all set.
- Arithmetic: pos is unsigned PW bits. Wrap is detected explicitly by comparison; pos never relies on natural PW-bit overflow, because WIDTH may not be a power of two.

## Timing
- Reset values (rst_n_i low at a clock edge) take effect on that edge:
  - pos_q = 0, ruler_o = 1, dir_q = 1 (R), cnt = 0, edge_o = 0.
  - Reset overrides any step or tick in the same cycle.
- Step latency: pos_o, dir_o and ruler_o change on the clock edge that samples step = 1. edge_o follows on the same edge.
- Tick period: the first tick occurs PRESCALE cycles after run_i rises. Subsequent ticks are every PRESCALE cycles.
- stb_i held high for N cycles produces N steps. No edge detection is performed.
- bar_i changes ruler_o combinationally with zero latency.

## Configuration
- Macro: RULER_SCAN_BAR_EN.
- Defined: bar_i selects bar-graph decode when 1 and one-hot decode when 0.
- Undefined: bar_i is ignored, ruler_o is always one-hot, and no thermometer logic is synthesised. The port remains in the interface.

## Structure
- Package ruler_pkg holds:
  - Mode constants MODE_WRAP = 2'b00, MODE_BOUNCE = 2'b01, MODE_STOP = 2'b10, MODE_HOLD = 2'b11.
  - Direction constants DIR_RIGHT = 1'b1, DIR_LEFT = 1'b0.
- Sub-module ruler_tick is the prescaler: parameter PRESCALE; ports clk_i, rst_n_i, run_i, tick_o.
- The top level contains the position/direction update logic, edge_o and the output decode.

## Test plan
- Reset, then WIDTH = 8, WRAP, dir_i = 1, five stb_i pulses -> pos_o sequence 0, 7, 6, 5, 4, 3; ruler_o = 0x80 after the first pulse; edge_o pulses once.
- WIDTH = 5, BOUNCE, start at pos 0 moving R, 10 steps -> pos 1, 2, 3, 4, 3, 2, 1, 0, 1, 2; dir_o flips after pos 4 and after pos 0; dir_i toggled during the run has no effect.
- STOP, dir_i = 0, 9 steps from pos 0 with WIDTH = 8 -> pos stops at 7 and stays; edge_o pulses on each step at 7; dir_i = 1 plus one step -> pos 6.
- PRESCALE = 4, run_i = 1 for 13 cycles, then 0 -> ticks after cycles 4, 8 and 12, giving 3 steps; stb_i asserted coincident with the cycle-8 tick -> still a single step.
- rst_n_i low mid-sequence at pos 5 with stb_i high -> next edge gives pos_o = 0, ruler_o = 1, dir_o = 1, edge_o = 0.
- With RULER_SCAN_BAR_EN defined, pos 3, bar_i = 1 -> ruler_o = 0x0F; bar_i = 0 -> 0x08 in the same cycle. Without the macro, bar_i = 1 -> 0x08.
